// File: rtl/scan_data_reg_if.sv
// Strobe, serial and parallel signals between the control FSM side and scan_data_reg.
interface scan_data_reg_if #(
  parameter int unsigned WIDTH = 8
);
  logic             reset;
  logic             run;
  logic             shift;
  logic             update;
  logic             tdi;
  logic [WIDTH-1:0] pin;
  logic             tdo;
  logic [WIDTH-1:0] pout;
  logic             upd_valid;
  logic             len_err;
  logic [7:0]       bit_cnt;

  modport master (
    output reset, run, shift, update, tdi, pin,
    input  tdo, pout, upd_valid, len_err, bit_cnt
  );

  modport slave (
    input  reset, run, shift, update, tdi, pin,
    output tdo, pout, upd_valid, len_err, bit_cnt
  );
endinterface

// File: rtl/scan_data_reg.sv
// Serial-in/parallel-out data register: capture on run, LSB-first shift, and a
// length-checked transfer to a held parallel output on the rising edge of update.
module scan_data_reg #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rs,
  scan_data_reg_if.slave bus
);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] pout;
  logic [7:0]       bit_cnt;
  logic             upd_d;
  logic             upd_valid;
  logic             len_err;

  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      sreg      <= '0;
      pout      <= '0;
      bit_cnt   <= '0;
      upd_d     <= 1'b0;
      upd_valid <= 1'b0;
      len_err   <= 1'b0;
    end else if (bus.reset) begin
      sreg      <= '0;
      bit_cnt   <= '0;
      upd_d     <= 1'b0;
      upd_valid <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      upd_d     <= bus.update;
      upd_valid <= 1'b0;
      if (bus.update && !upd_d) begin
        // Only an exact-length shift may reach pout; anything else is sticky-flagged.
        if (bit_cnt == 8'(WIDTH)) begin
          pout      <= sreg;
          upd_valid <= 1'b1;
        end else begin
          len_err <= 1'b1;
        end
      end else if (bus.shift) begin
        sreg <= {bus.tdi, sreg[WIDTH-1:1]};
        if (bit_cnt != 8'hFF) begin
          bit_cnt <= bit_cnt + 8'd1;
        end
      end else if (bus.run) begin
        sreg    <= bus.pin;
        bit_cnt <= '0;
      end
    end
  end

  assign bus.tdo       = sreg[0];
  assign bus.pout      = pout;
  assign bus.bit_cnt   = bit_cnt;
  assign bus.upd_valid = upd_valid;
  assign bus.len_err   = len_err;

endmodule

// File: doc/scan_data_reg.md
# scan_data_reg

Serial-in/parallel-out data register that sits directly downstream of the one-hot control FSM (states reset / run / shift / update) and consumes its `reset`, `run`, `shift` and `update` strobes.
- In run, it captures a parallel input word.
- In shift, it moves data serially from `tdi` to `tdo`, LSB first, and counts the bits shifted.
- On entry to update, it transfers the shift chain to a held parallel output, but only if exactly `WIDTH` bits were shifted.
- Any other shift length leaves the output unchanged and raises a sticky length error.

## Interface
- `WIDTH`, default 8: length of the shift chain and of the parallel output. Legal range 2..254.
- `clk`, in, 1: system clock. All state changes occur on its rising edge.
- `rs`, in, 1: asynchronous, active-high reset.
- `reset`, in, 1: synchronous clear strobe from the FSM reset state.
- `run`, in, 1: capture strobe from the FSM run/idle state.
- `shift`, in, 1: shift-enable strobe from the FSM shift state.
- `update`, in, 1: update strobe from the FSM update state.
- `tdi`, in, 1: serial data in.
- `pin`, in, `WIDTH`: parallel word captured while `run` is high.
- `tdo`, out, 1: serial data out, equal to `sreg[0]` (taken from the register, no combinational path from `tdi`).
- `pout`, out, `WIDTH`: held parallel output register.
- `upd_valid`, out, 1: one-cycle pulse indicating that `pout` was just loaded.
- `len_err`, out, 1: sticky flag set by an update that followed a wrong shift length.
- `bit_cnt`, out, 8: number of bits shifted since the last capture. Saturates at 255.

## Operation
- Internal state:
  - `sreg[WIDTH-1:0]`: the shift chain.
  - `bit_cnt`.
  - `upd_d`: `update` delayed by one cycle, used for edge detection.
  - `pout`, `upd_valid`, `len_err`.
- `rs` high clears all of the above to 0 immediately, independent of `clk`, and holds them at 0 while asserted. Every output reads 0 during and after reset.
- At each rising edge with `rs` low, exactly one action applies, chosen by this priority (highest first):
  1. `reset` high: synchronous clear of `sreg`, `bit_cnt`, `len_err` and `upd_valid`. `pout` is held. `upd_d` is set to 0.
  2. `update` high and `upd_d` low (rising edge of `update`):
     - If `bit_cnt == WIDTH`: `pout <= sreg`, `upd_valid <= 1`. `len_err` keeps its value.
     - Otherwise: `pout` is held, `upd_valid <= 0`, `len_err <= 1`.
     - `sreg` and `bit_cnt` are held.
  3. `shift` high:
     - `sreg <= {tdi, sreg[WIDTH-1:1]}`.
     - `bit_cnt <= bit_cnt + 1`, saturating at 255 with no wrap.
  4. `run` high: `sreg <= pin`, `bit_cnt <= 0`.
  5. None of the above: all state is held.
- In every case except rule 1, `upd_d <= update`.
- `upd_valid` is 0 in every cycle except the single cycle after a qualifying update edge.
- If `update` stays high for several cycles, only its first cycle acts; the remaining cycles behave like rule 5.
- Simultaneous strobes are illegal for the FSM to produce, but they are resolved strictly by the priority above.
- Over-long shifts: once the count passes `WIDTH`, the earliest bits fall off at `tdo` and the update is rejected. It still counts as an error even though `sreg` holds the last `WIDTH` bits.
- Only `rs` or the `reset` strobe clears `len_err`. Successful updates do not clear it.

## Timing
- All outputs are registered, except `tdo`, which is a direct copy of the `sreg[0]` flop.
- Capture latency: `pin` is sampled on the edge where `run` is high and is visible on `tdo` (as bit 0) immediately after that edge.
- Shift: each edge with `shift` high presents the next bit on `tdo`. A `WIDTH`-bit shift takes exactly `WIDTH` edges.
- Update latency: `pout` and `upd_valid` change on the first edge where `update` is high. `upd_valid` drops on the following edge.
- Assertion of `rs` is asynchronous. Deassertion is intended to be synchronous to `clk` (a synchronizer is provided outside this block). There is no recovery cycle: the first edge with `rs` low already evaluates the priority rules.
- Reset mid-shift, by either `rs` or the `reset` strobe, discards the partial word. `pout` keeps the last good value under the `reset` strobe, but is cleared by `rs`.

## Test plan
- Reset: assert `rs` mid-cycle with `sreg` non-zero → `sreg`, `pout`, `tdo`, `bit_cnt`, `len_err` and `upd_valid` all read 0 before the next edge.
- Capture-and-shift, `WIDTH`=8:
  - Stimulus: run with `pin`=8'hA5, then shift 8 cycles with `tdi` bits (LSB first) of 8'h3C, then update.
  - Required: `tdo` sequence is 1,0,1,0,0,1,0,1; `pout`=8'h3C; `upd_valid` high for exactly 1 cycle; `len_err`=0.
- Short shift: capture, shift 5 bits, update → `pout` keeps its previous value, `len_err`=1, `upd_valid`=0. `len_err` stays 1 through a later good update and clears only on the `reset` strobe.
- Long shift: capture, shift 10 bits, update → `bit_cnt`=10, update rejected, `len_err`=1.
- Held update: `update` high for 3 cycles after a good 8-bit shift → exactly one `upd_valid` pulse, and `pout` is loaded once.
- Priority: `reset` and `update` high together after a good shift → state is cleared, `pout` is held, `upd_valid`=0. Separately, `shift` and `run` high together → the shift wins and `bit_cnt` increments.
